bit_serializer_1011_src: RTL and testbench
==========================================

// Module: bit_serializer_1011_src
// PURPOSE
//  Upstream feeder for the 1011 sequence-detector stage. Accepts parallel words on a valid/ready handshake
//  and emits them one bit per clock on a serial line that drives the detector's inp_bit.
//  Emits 0 when no word is in flight, so any partial match in the detector is broken between bursts.
//  Back-to-back words stream with no gap bits.
// PARAMETERS
//  WIDTH    8                 data word width in bits; must be >= 2
//  CNT_W    $clog2(WIDTH)     bit-index counter width (derived; do not override)
//  WCNT_W   16                width of the accepted-word counter
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high
//  in_data    in   WIDTH   parallel word
//  in_valid   in   1       in_data valid
//  in_ready   out  1       block can accept this cycle
//  lsb_first  in   1       bit order; sampled per word at handshake (0 = MSB first)
//  bit_out    out  1       serial bit to the detector inp_bit
//  bit_valid  out  1       bit_out carries payload (1) or idle fill (0)
//  word_cnt   out  WCNT_W  words accepted since reset; wraps
// BEHAVIOUR
//  Reset is synchronous, active-high, on clock clk. While reset=1: state=IDLE, shift reg=0, cnt=0,
//    word_cnt=0, bit_out=0, bit_valid=0, in_ready=0.
//  Handshake: a word is accepted at the rising edge where in_valid && in_ready. in_data is ignored otherwise.
//  States are IDLE, SHIFT and PARITY. PARITY exists only with SER_PARITY_EN.
//  IDLE: in_ready=1, bit_out=0, bit_valid=0. On accept: load the shift reg, latch lsb_first, cnt=0, go to SHIFT.
//  SHIFT: bit_valid=1. bit_out=shreg[WIDTH-1] (MSB first) or shreg[0] (LSB first).
//    Each cycle: shift toward the output end and increment cnt.
//  Last bit is the SHIFT cycle with cnt==WIDTH-1:
//    - Without parity: in_ready=1. On accept, reload and stay in SHIFT (no bubble). Otherwise go to IDLE.
//    - With parity: in_ready=0 and the FSM goes to PARITY.
//  In SHIFT with cnt!=WIDTH-1: in_ready=0.
//  PARITY: bit_valid=1, bit_out = even-parity bit (XOR of all WIDTH word bits), in_ready=1.
//    On accept go to SHIFT; otherwise go to IDLE.
//  Latency: first payload bit appears on bit_out in the cycle after the accepting edge.
//    A word occupies WIDTH cycles, or WIDTH+1 with parity.
//  bit_out and bit_valid are driven from registers/state only; there is no combinational path from inputs.
//    in_ready depends on state and cnt only, never on in_valid.
//  word_cnt increments by 1 on every accept and wraps from 2^WCNT_W-1 to 0.
//  Reset mid-word: the partial word is discarded. bit_valid=0 from the cycle after the reset edge.
//    No parity bit is sent for the aborted word.
//  Upstream may hold in_valid high across a not-ready cycle. in_data must stay stable until accepted.
// CONFIGURATION
//  Macro SER_PARITY_EN:
//    - Defined: after each word, append one even-parity bit (bit_valid=1); throughput is WIDTH/(WIDTH+1).
//    - Undefined: no PARITY state and no parity logic; throughput is 1 bit/cycle.
//  Port list is identical in both builds.
// STRUCTURE
//  Shared package seq_pkg:
//    - ser_state_t enum {IDLE, SHIFT, PARITY}
//    - SER_WIDTH_DEF=8 and WCNT_W_DEF=16 constants
//  No sub-module. FSM, shift register and counters are in one file.
//  Instantiated beside the detector: bit_out -> inp_bit, with shared clk and reset.
// TESTING
//  1. MSB-first, 8'hB0, single accept -> bit_out 1,0,1,1,0,0,0,0 on cycles +1..+8 with bit_valid=1;
//     then bit_valid=0; word_cnt=1; downstream detector pulses seq_seen once.
//  2. Back-to-back 8'hB0, 8'h0B with in_valid held high -> bit_valid high for 16 consecutive cycles;
//     in_ready=1 only on cycles +8 (and the initial IDLE cycle); word_cnt=2.
//  3. lsb_first=1, 8'h0D -> bit_out 1,0,1,1,0,0,0,0; lsb_first toggled mid-word has no effect on the current word.
//  4. Reset asserted on the 3rd bit of 8'hFF -> cycle after the edge: bit_valid=0, in_ready=0;
//     after release word_cnt=0 and in_ready=1.
//  5. SER_PARITY_EN, 8'hB0 -> 8 payload bits then parity bit 1, bit_valid=1 for 9 cycles;
//     in_ready=1 only on the parity cycle; 8'hB1 gives parity bit 0.
//  6. word_cnt wrap: 2^16 accepts of random data -> word_cnt returns to 0; no lost bits (scoreboard compare).

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 sequence-detector slice.
//   ser_state_t   : serializer FSM states (PARITY is only reached when
//                   SER_PARITY_EN is defined)
//   SER_WIDTH_DEF : default serializer word width
//   WCNT_W_DEF    : default width of the accepted-word counter
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    localparam int SER_WIDTH_DEF = 8;
    localparam int WCNT_W_DEF    = 16;

endpackage : seq_pkg

// File: rtl/bit_serializer_1011_src.sv
// bit_serializer_1011_src
// Upstream feeder for the 1011 sequence detector. Takes parallel words on a
// valid/ready handshake and shifts them out one bit per clock. Between bursts
// the serial line idles at 0, so any partial match in the detector is broken.
// Back-to-back words stream with no gap bits.
//
// Optional feature macro: SER_PARITY_EN
//   defined   : one even-parity bit (XOR of the word) follows every word
//   undefined : no parity state or logic, 1 payload bit per cycle
//
// Ports
//   clk       in   1       clock, rising edge
//   reset     in   1       synchronous, active-high
//   in_data   in   WIDTH   parallel word
//   in_valid  in   1       in_data valid
//   in_ready  out  1       word can be accepted this cycle
//   lsb_first in   1       bit order, sampled at the handshake (0 = MSB first)
//   bit_out   out  1       serial bit to the detector inp_bit
//   bit_valid out  1       bit_out carries payload (1) or idle fill (0)
//   word_cnt  out  WCNT_W  words accepted since reset, wrapping
module bit_serializer_1011_src
    import seq_pkg::*;
#(
    parameter int WIDTH  = SER_WIDTH_DEF,
    parameter int CNT_W  = $clog2(WIDTH),
    parameter int WCNT_W = WCNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              lsb_first,
    output logic              bit_out,
    output logic              bit_valid,
    output logic [WCNT_W-1:0] word_cnt
);

    ser_state_t        state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lsb_q, lsb_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
`ifdef SER_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic last_bit;
    logic ready_raw;
    logic accept;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Readiness is a function of state and bit index only; reset merely
    // masks it so nothing is advertised while the block is held in reset.
    always_comb begin
        ready_raw = 1'b0;
        case (state_q)
            IDLE:    ready_raw = 1'b1;
`ifdef SER_PARITY_EN
            PARITY:  ready_raw = 1'b1;
`else
            SHIFT:   ready_raw = last_bit;
`endif
            default: ready_raw = 1'b0;
        endcase
    end

    assign in_ready = ready_raw & ~reset;
    assign accept   = in_valid & ready_raw;

    // Next-state logic. The case covers what happens without a handshake;
    // an accept always means "load the word and start shifting", whichever
    // ready state it happened in, so it is applied afterwards as an override.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        lsb_d      = lsb_q;
        word_cnt_d = word_cnt_q;
`ifdef SER_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: ;
            SHIFT: begin
                if (last_bit) begin
`ifdef SER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end else begin
                    // Move the next bit to whichever end drives bit_out.
                    shreg_d = lsb_q ? {1'b0, shreg_q[WIDTH-1:1]}
                                    : {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q + 1'b1;
                end
            end
`ifdef SER_PARITY_EN
            PARITY:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d    = SHIFT;
            shreg_d    = in_data;
            lsb_d      = lsb_first;
            cnt_d      = '0;
            word_cnt_d = word_cnt_q + 1'b1;
`ifdef SER_PARITY_EN
            // The word is consumed by the shifter, so its parity is
            // captured up front.
            parity_d   = ^in_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            lsb_q      <= 1'b0;
            word_cnt_q <= '0;
`ifdef SER_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            lsb_q      <= lsb_d;
            word_cnt_q <= word_cnt_d;
`ifdef SER_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Serial outputs come from registers only.
    always_comb begin
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        case (state_q)
            SHIFT: begin
                bit_valid = 1'b1;
                bit_out   = lsb_q ? shreg_q[0] : shreg_q[WIDTH-1];
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                bit_valid = 1'b1;
                bit_out   = parity_q;
            end
`endif
            default: ;
        endcase
    end

    assign word_cnt = word_cnt_q;

endmodule : bit_serializer_1011_src

// File: tb/tb_bit_serializer_1011_src.sv
// Testbench for bit_serializer_1011_src.
// Stimulus pushes the expected serial bit stream of every accepted word into a
// queue; an independent monitor pops one entry per payload cycle.
// Respects SER_PARITY_EN the same way the design does.
module tb_bit_serializer_1011_src;

    localparam int W  = 8;
    localparam int WC = 16;
`ifdef SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          lsb_first;
    logic          bit_out;
    logic          bit_valid;
    logic [WC-1:0] word_cnt;

    bit_serializer_1011_src #(.WIDTH(W), .WCNT_W(WC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lsb_first (lsb_first),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic          exp_q[$];
    logic [WC-1:0] exp_wcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word is sent as its bits in the requested order, followed
    // by the XOR of all its bits when parity is enabled.
    task automatic push_word(input logic [W-1:0] w, input logic lsb);
        for (int i = 0; i < W; i++)
            exp_q.push_back(lsb ? w[i] : w[W-1-i]);
        if (P == 1)
            exp_q.push_back(^w);
        exp_wcnt = exp_wcnt + 1'b1;
        $display("accept word=%h lsb_first=%0d word_cnt=%0d", w, lsb, exp_wcnt);
    endtask

    // Monitor: every payload cycle consumes one expected bit; idle cycles
    // must show 0 and must not occur while bits are still owed.
    always @(negedge clk) begin
        if (!reset) begin
            if (bit_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_bit: got bit_valid=1 required 0 at %0t", $time);
                end else begin
                    logic e;
                    e = exp_q.pop_front();
                    check("bit_out", {31'd0, bit_out}, {31'd0, e});
                end
            end else begin
                check("idle_fill", {31'd0, bit_out}, 32'd0);
                if (exp_q.size() != 0) begin
                    total++; bad++;
                    $display("FAIL bubble: got bit_valid=0 required 1 (%0d bits pending) at %0t",
                             exp_q.size(), $time);
                end
            end
        end
    end

    // Called in a cycle where the DUT should be ready. Presents w, checks the
    // ready/valid pattern over the word, toggles lsb_first mid-word, and
    // returns at the start of the word's final cycle.
    task automatic drive_word(input logic [W-1:0] w, input logic lsb,
                              input logic has_next, input logic [W-1:0] nxt);
        in_data   = w;
        lsb_first = lsb;
        in_valid  = 1'b1;
        @(negedge clk);
        check("rdy_at_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        push_word(w, lsb);
        if (has_next) in_data = nxt;
        else          in_valid = 1'b0;
        for (int k = 1; k < W + P; k++) begin
            @(negedge clk);
            check("valid_mid", {31'd0, bit_valid}, 32'd1);
            check("rdy_mid",   {31'd0, in_ready},  32'd0);
            @(posedge clk); #1;
            lsb_first = ~lsb_first;
        end
    endtask

    task automatic tail();
        @(negedge clk);
        check("valid_last", {31'd0, bit_valid}, 32'd1);
        check("rdy_last",   {31'd0, in_ready},  32'd1);
        check("word_cnt",   {16'd0, word_cnt},  {16'd0, exp_wcnt});
        @(posedge clk); #1;
        @(negedge clk);
        check("valid_after", {31'd0, bit_valid}, 32'd0);
        check("rdy_idle",    {31'd0, in_ready},  32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        logic         l;
        logic         acc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        lsb_first = 1'b0;
        exp_wcnt  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid",    {31'd0, bit_valid}, 32'd0);
        check("rst_bit_out",  {31'd0, bit_out},   32'd0);
        check("rst_ready",    {31'd0, in_ready},  32'd0);
        check("rst_word_cnt", {16'd0, word_cnt},  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single MSB-first word
        drive_word(8'hB0, 1'b0, 1'b0, 8'h00);
        tail();

        // Back-to-back words with in_valid held high
        drive_word(8'hB0, 1'b0, 1'b1, 8'h0B);
        drive_word(8'h0B, 1'b0, 1'b0, 8'h00);
        tail();

        // LSB-first word; lsb_first toggles mid-word inside drive_word
        drive_word(8'h0D, 1'b1, 1'b0, 8'h00);
        tail();

        // Parity of 1 and 0 (payload-only stream when parity is disabled)
        drive_word(8'hB0, 1'b0, 1'b1, 8'hB1);
        drive_word(8'hB1, 1'b0, 1'b0, 8'h00);
        tail();

        // Reset during the third bit of 8'hFF
        in_data   = 8'hFF;
        lsb_first = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        check("rdy_before_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        push_word(8'hFF, 1'b0);
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_valid", {31'd0, bit_valid}, 32'd0);
        check("midrst_ready", {31'd0, in_ready},  32'd0);
        @(posedge clk); #1;
        reset    = 1'b0;
        exp_wcnt = '0;
        @(negedge clk);
        check("postrst_word_cnt", {16'd0, word_cnt}, 32'd0);
        check("postrst_ready",    {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Randomized traffic: random data, order, gaps and junk lsb_first
        // while not ready.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    in_data   = W'($urandom);
                    lsb_first = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            w         = W'($urandom);
            l         = 1'($urandom_range(0, 1));
            in_data   = w;
            lsb_first = l;
            in_valid  = 1'b1;
            acc       = 1'b0;
            for (int t = 0; t < 40 && !acc; t++) begin
                @(negedge clk);
                if (in_ready) lsb_first = l;
                else          lsb_first = 1'($urandom_range(0, 1));
                acc = in_ready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                total++; bad++;
                $display("FAIL accept_timeout: got in_ready=0 for 40 cycles required 1");
                break;
            end
            push_word(w, l);
            check("rand_word_cnt", {16'd0, word_cnt}, {16'd0, exp_wcnt});
        end
        in_valid = 1'b0;

        for (int t = 0; t < 40 && exp_q.size() != 0; t++)
            @(posedge clk);
        #1;
        @(negedge clk);
        check("drain", exp_q.size(), 32'd0);
        check("final_word_cnt", {16'd0, word_cnt}, {16'd0, exp_wcnt});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bit_serializer_1011_src
